// File: rtl/comm_slave.sv
// Device-side UART command endpoint: two RX bytes form a 16-bit command, single TX bytes carry responses.
// Build option COMM_TIMEOUT_EN drops a lone high byte after TIMEOUT idle cycles in WAIT_LO.
module comm_slave #(
  parameter int BAUD_DIV = 108,
  parameter int TIMEOUT  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  // state    | meaning
  // RX_*     | idle / mid-start check / data bits / stop bit
  // WAIT_*   | expecting high byte / holding high byte, expecting low byte
  // TX_*     | idle / shifting a frame out
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

  localparam logic [11:0] BAUD_LD = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LD = 12'(BAUD_DIV / 2 - 1);

  rx_state_t   rx_state;
  asm_state_t  asm_state;
  tx_state_t   tx_state;

  logic        rx_meta, rx_s, rx_d;
  logic [11:0] rx_baud;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        byte_vld, frame_err;
  logic [7:0]  hi_byte;
  logic        start_det;

  logic [11:0] tx_baud;
  logic [3:0]  tx_bit;
  logic [8:0]  tx_data;

  assign start_det = (rx_state == RX_IDLE) && rx_d && !rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_baud   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= RX;
      rx_s      <= rx_meta;
      rx_d      <= rx_s;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (start_det) begin
            rx_state <= RX_START;
            rx_baud  <= HALF_LD;
          end
        end
        RX_START: begin
          if (rx_baud == 12'd0) begin
            if (!rx_s) begin
              rx_state <= RX_DATA;
              rx_baud  <= BAUD_LD;
              rx_bit   <= 4'd7;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_baud <= rx_baud - 12'd1;
          end
        end
        RX_DATA: begin
          if (rx_baud == 12'd0) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_baud  <= BAUD_LD;
            if (rx_bit == 4'd0) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit - 4'd1;
          end else begin
            rx_baud <= rx_baud - 12'd1;
          end
        end
        RX_STOP: begin
          if (rx_baud == 12'd0) begin
            byte_vld  <= rx_s;
            frame_err <= !rx_s;
            rx_state  <= RX_IDLE;
          end else begin
            rx_baud <= rx_baud - 12'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef COMM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LD = TW'(TIMEOUT - 1);
  logic [TW-1:0] to_cnt;
`endif

  // Set is ordered after clear so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state <= WAIT_HI;
      hi_byte   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
`ifdef COMM_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      if (clr_cmd_rdy || (start_det && asm_state == WAIT_HI)) cmd_rdy <= 1'b0;
      if (frame_err) begin
        asm_state <= WAIT_HI;
      end else if (byte_vld) begin
        if (asm_state == WAIT_HI) begin
          hi_byte   <= rx_shift;
          asm_state <= WAIT_LO;
`ifdef COMM_TIMEOUT_EN
          to_cnt    <= TO_LD;
`endif
        end else begin
          cmd       <= {hi_byte, rx_shift};
          cmd_rdy   <= 1'b1;
          asm_state <= WAIT_HI;
        end
      end
`ifdef COMM_TIMEOUT_EN
      else if (asm_state == WAIT_LO) begin
        if (start_det)             to_cnt    <= TO_LD;
        else if (to_cnt == '0)     asm_state <= WAIT_HI;
        else                       to_cnt    <= to_cnt - 1'b1;
      end
`endif
    end
  end

  // tx_data carries the stop bit in its MSB so shifting fills the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      TX        <= 1'b1;
      tx_busy   <= 1'b0;
      resp_sent <= 1'b0;
      tx_baud   <= '0;
      tx_bit    <= '0;
      tx_data   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            tx_data   <= {1'b1, resp};
            TX        <= 1'b0;
            tx_busy   <= 1'b1;
            resp_sent <= 1'b0;
            tx_baud   <= BAUD_LD;
            tx_bit    <= 4'd9;
            tx_state  <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (tx_baud == 12'd0) begin
            tx_baud <= BAUD_LD;
            if (tx_bit == 4'd0) begin
              TX        <= 1'b1;
              tx_busy   <= 1'b0;
              resp_sent <= 1'b1;
              tx_state  <= TX_IDLE;
            end else begin
              TX      <= tx_data[0];
              tx_data <= {1'b1, tx_data[8:1]};
              tx_bit  <= tx_bit - 4'd1;
            end
          end else begin
            tx_baud <= tx_baud - 12'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comm_slave.sv
// Scoreboard bench for comm_slave: stimulus queues expected commands/frames, monitors compare.
module tb_comm_slave;
  localparam int B = 108;
  // cmd_rdy rises this many cycles after the low byte's start bit is driven
  localparam int CMD_LAT = 1030;

  logic clk = 1'b0;
  logic rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, tx_busy;
  logic [15:0] cmd;
  logic [7:0] resp;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct { logic [15:0] val; int at; } cmd_exp_t;
  cmd_exp_t cmd_q[$];
  logic [7:0] tx_q[$];

  comm_slave #(.BAUD_DIV(B), .TIMEOUT(5000)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val,
                           input logic push, input logic [15:0] exp_val);
    cmd_exp_t e;
    @(posedge clk); #1;
    if (push) begin
      e.val = exp_val;
      e.at  = cyc + CMD_LAT;
      cmd_q.push_back(e);
    end
    RX = 1'b0;
    repeat (B) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 RX = b[i];
      repeat (B) @(posedge clk);
    end
    #1 RX = stop_val;
    repeat (B) @(posedge clk);
    #1 RX = 1'b1;
    if (!stop_val) begin
      repeat (B) @(posedge clk);
      #1;
    end
  endtask

  // command monitor
  initial begin
    logic rdy_q;
    cmd_exp_t e;
    rdy_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && cmd_rdy && !rdy_q) begin
        if (cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd_unexpected: got %h expected none", cmd);
        end else begin
          e = cmd_q.pop_front();
          chk("cmd_val", 32'(cmd), 32'(e.val));
          chk("cmd_cycle", 32'(cyc), 32'(e.at));
        end
      end
      rdy_q = cmd_rdy;
    end
  end

  // transmit monitor: checks the line every cycle of the frame
  initial begin
    logic busy_q, aborted, eb;
    logic [7:0] eb_byte;
    int n, errs;
    busy_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && tx_busy && !busy_q) begin
        eb_byte = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
        n = 0; errs = 0; aborted = 1'b0;
        while (!aborted && tx_busy && n < 2000) begin
          if (rst) aborted = 1'b1;
          else begin
            if (n < B)          eb = 1'b0;
            else if (n < 9 * B) eb = eb_byte[(n - B) / B];
            else                eb = 1'b1;
            if (TX !== eb || resp_sent !== 1'b0) errs++;
            n++;
            @(negedge clk);
          end
        end
        if (!aborted) begin
          chk("tx_wave_errs", 32'(errs), 32'd0);
          chk("tx_busy_len", 32'(n), 32'(10 * B));
          chk("resp_sent_end", 32'(resp_sent), 32'd1);
          chk("tx_idle_high", 32'(TX), 32'd1);
        end
      end
      busy_q = tx_busy;
    end
  end

  initial begin
    RX = 1'b1; clr_cmd_rdy = 1'b0; resp = 8'h00; send_resp = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_TX", 32'(TX), 32'd1);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_resp_sent", 32'(resp_sent), 32'd0);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // single command and explicit clear
    send_byte(8'h80, 1'b1, 1'b0, 16'h0);
    send_byte(8'h00, 1'b1, 1'b1, 16'h8000);
    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    @(negedge clk);
    chk("clr_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("cmd_hold", 32'(cmd), 32'h8000);

    // back-to-back commands, cmd_rdy dropped by the next high byte's start bit
    send_byte(8'h01, 1'b1, 1'b0, 16'h0);
    send_byte(8'h23, 1'b1, 1'b1, 16'h0123);
    fork
      send_byte(8'hA5, 1'b1, 1'b0, 16'h0);
      begin
        @(posedge clk); #1;
        repeat (3) @(negedge clk);
        chk("rdy_before_drop", 32'(cmd_rdy), 32'd1);
        @(negedge clk);
        chk("rdy_drop_at_start", 32'(cmd_rdy), 32'd0);
      end
    join
    send_byte(8'hC3, 1'b1, 1'b1, 16'hA5C3);

    // response frame; a second request mid-frame must be ignored
    @(posedge clk); #1 resp = 8'hA5; send_resp = 1'b1; tx_q.push_back(8'hA5);
    @(posedge clk); #1 send_resp = 1'b0; resp = 8'h00;
    repeat (498) @(posedge clk);
    #1 resp = 8'hFF; send_resp = 1'b1;
    @(posedge clk); #1 send_resp = 1'b0;
    for (int i = 0; i < 2000 && tx_busy; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk("resp_sent_hold", 32'(resp_sent), 32'd1);

    // lone high byte followed by a long gap
    send_byte(8'h12, 1'b1, 1'b0, 16'h0);
    repeat (6000) @(posedge clk);
`ifdef COMM_TIMEOUT_EN
    send_byte(8'h34, 1'b1, 1'b0, 16'h0);
    send_byte(8'h56, 1'b1, 1'b1, 16'h3456);
`else
    send_byte(8'h34, 1'b1, 1'b1, 16'h1234);
    send_byte(8'h56, 1'b1, 1'b0, 16'h0);
`endif

    // framing error resync and a start glitch between the bytes
    send_byte(8'h55, 1'b0, 1'b0, 16'h0);
    send_byte(8'h12, 1'b1, 1'b0, 16'h0);
    @(posedge clk); #1 RX = 1'b0;
    repeat (20) @(posedge clk);
    #1 RX = 1'b1;
    repeat (300) @(posedge clk);
    send_byte(8'h34, 1'b1, 1'b1, 16'h1234);

    // reset during the second byte and during a transmit
    send_byte(8'hAB, 1'b1, 1'b0, 16'h0);
    @(posedge clk); #1 resp = 8'h3C; send_resp = 1'b1; tx_q.push_back(8'h3C);
    @(posedge clk); #1 send_resp = 1'b0; RX = 1'b0;
    repeat (500) @(posedge clk);
    #1 rst = 1'b1; RX = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_TX", 32'(TX), 32'd1);
    chk("midrst_tx_busy", 32'(tx_busy), 32'd0);
    chk("midrst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("midrst_cmd", 32'(cmd), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    send_byte(8'h0F, 1'b1, 1'b0, 16'h0);
    send_byte(8'h0F, 1'b1, 1'b1, 16'h0F0F);

    for (int i = 0; i < 3000 && (cmd_q.size() != 0 || tx_busy); i++) @(posedge clk);
    repeat (5) @(posedge clk);
    if (cmd_q.size() != 0) begin
      total++; bad++;
      $display("FAIL cmd_missing: got %0d pending expected 0", cmd_q.size());
    end
    if (tx_q.size() != 0) begin
      total++; bad++;
      $display("FAIL tx_missing: got %0d pending expected 0", tx_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
